// File: rtl/hififo_pkg.sv
// ============================================================================
// Module      : hififo_pkg
// Description : Shared hififo constants and the tpc arbiter state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hififo_pkg;

  localparam int         HIFIFO_DW     = 64;
  localparam logic [7:0] TPC_HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HDR   = 2'd1,
    ARB_BURST = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               set bit of valid at or above ptr, wrapping modulo N_REQ.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int w_dist;
  int w_best;

  // Distance from ptr in rr order; the smallest distance among valid bits wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_best = N_REQ;
    w_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = i - int'(ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + N_REQ;
      end
      if (valid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tpc_arbiter.sv
// ============================================================================
// Module      : tpc_arbiter
// Description : Round-robin burst arbiter sharing one hififo tpc channel
//               between N_REQ requesters. Optional macro TPC_ARB_HEADER_EN
//               prefixes every burst with a sequence-numbered header word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tpc_arbiter
  import hififo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [HIFIFO_DW*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_read,
  input  logic                       tpc_ready,
  output logic                       tpc_write,
  output logic [HIFIFO_DW-1:0]       tpc_data,
  output logic [2:0]                 grant_idx,
  output logic                       busy
);

  localparam int IDX_W = 3;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_write;
  logic [HIFIFO_DW-1:0] r_data;

  logic [HIFIFO_DW-1:0] w_words [N_REQ];
  logic [HIFIFO_DW-1:0] w_sel_data;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_found;
  logic                 w_xfer;
  logic                 w_burst_end;
  logic [IDX_W-1:0]     w_ptr_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_words[gi] = req_data[gi*HIFIFO_DW +: HIFIFO_DW];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = w_words[i];
      end
    end
  end

  // flush suppresses the transfer so no requester pops a word that would be dropped.
  assign w_xfer      = (r_state == ARB_BURST) && w_sel_valid && tpc_ready && !flush;
  assign w_burst_end = w_xfer && (w_sel_last || (r_count == CNT_W'(MAX_BURST - 1)));
  assign w_ptr_next  = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

`ifdef TPC_ARB_HEADER_EN
  logic [15:0]          r_seq;
  logic [HIFIFO_DW-1:0] w_hdr_word;

  assign w_hdr_word = {TPC_HDR_MAGIC, 5'd0, r_grant, r_seq, 32'd0};
`endif

  always_comb begin
    w_next_state = r_state;
    req_read     = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
`ifdef TPC_ARB_HEADER_EN
          w_next_state = ARB_HDR;
`else
          w_next_state = ARB_BURST;
`endif
        end
      end
`ifdef TPC_ARB_HEADER_EN
      ARB_HDR: begin
        if (tpc_ready) begin
          w_next_state = ARB_BURST;
        end
      end
`endif
      ARB_BURST: begin
        for (int i = 0; i < N_REQ; i++) begin
          req_read[i] = w_xfer && (r_grant == IDX_W'(i));
        end
        if (w_burst_end) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else if (flush) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
`ifdef TPC_ARB_HEADER_EN
      r_seq   <= '0;
`endif
    end else if (flush) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
`ifdef TPC_ARB_HEADER_EN
      r_seq   <= '0;
`endif
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_found) begin
            r_grant <= w_pick_idx;
            r_count <= '0;
          end
        end
`ifdef TPC_ARB_HEADER_EN
        ARB_HDR: begin
          if (tpc_ready) begin
            r_write <= 1'b1;
            r_data  <= w_hdr_word;
            r_seq   <= r_seq + 16'd1;
          end
        end
`endif
        ARB_BURST: begin
          if (w_xfer) begin
            r_write <= 1'b1;
            r_data  <= w_sel_data;
            r_count <= r_count + CNT_W'(1);
            if (w_burst_end) begin
              r_ptr <= w_ptr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tpc_write = r_write;
  assign tpc_data  = r_data;
  assign grant_idx = r_grant;
  assign busy      = (r_state == ARB_BURST);

endmodule

`default_nettype wire

// File: tb/tb_tpc_arbiter.sv
// ============================================================================
// Module      : tb_tpc_arbiter
// Description : Self-checking bench for tpc_arbiter with requester queues and
//               a packet-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_tpc_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [N-1:0]     req_valid;
  logic [64*N-1:0]  req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_read;
  logic             tpc_ready;
  logic             tpc_write;
  logic [63:0]      tpc_data;
  logic [2:0]       grant_idx;
  logic             busy;

  always #5 clock = ~clock;

  tpc_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_read  (req_read),
    .tpc_ready (tpc_ready),
    .tpc_write (tpc_write),
    .tpc_data  (tpc_data),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Requester queues: bit 64 is the last flag, [63:0] the word.
  logic [64:0] q [N][$];
  int          tag_seq = 0;

  // Reference model of the arbiter at packet/burst level.
  bit          m_busy;
  bit          m_hdr;
  int          m_owner;
  int          m_words;
  int          m_ptr;
  logic        m_write;
  logic [63:0] m_data;
  logic [15:0] m_seq;
  int          m_writes;

  int p_valid = 100;
  int p_ready = 100;
  int p_flush = 0;
  bit toggle_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int total_left();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_hdr   = 0;
    m_owner = 0;
    m_words = 0;
    m_ptr   = 0;
    m_write = 0;
    m_data  = '0;
    m_seq   = '0;
  endtask

  task automatic push_packet(input int r, input int len, input bit has_last);
    for (int w = 0; w < len; w++) begin
      tag_seq++;
      q[r].push_back({(has_last && (w == len - 1)), 8'(r), 24'd0, 32'(tag_seq)});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0) && ($urandom_range(99) < p_valid);
      if (req_valid[i]) begin
        req_data[64*i +: 64] = q[i][0][63:0];
        req_last[i]          = q[i][0][64];
      end else begin
        req_data[64*i +: 64] = {$urandom, $urandom};
        req_last[i]          = 1'($urandom_range(1));
      end
    end
    if (toggle_ready) tpc_ready = ~tpc_ready;
    else              tpc_ready = ($urandom_range(99) < p_ready);
    flush = ($urandom_range(99) < p_flush);
  endtask

  // One clock: check req_read mid-cycle, advance the model, check registered outputs.
  task automatic cycle();
    logic [N-1:0] exp_read;
    bit           xfer;
    int           p;
    logic [64:0]  w;
    @(negedge clock);
    exp_read = '0;
    xfer     = 0;
    if (!flush && m_busy && req_valid[m_owner] && tpc_ready) begin
      xfer              = 1;
      exp_read[m_owner] = 1'b1;
    end
    chk("req_read", req_read, exp_read);
    m_write = 1'b0;
    if (flush) begin
      model_reset();
    end else if (m_hdr) begin
      if (tpc_ready) begin
        m_write = 1'b1;
        m_data  = {8'hA5, 8'(m_owner), m_seq, 32'd0};
        m_seq   = m_seq + 16'd1;
        m_hdr   = 0;
        m_busy  = 1;
      end
    end else if (!m_busy) begin
      p = pick(req_valid, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_words = 0;
`ifdef TPC_ARB_HEADER_EN
        m_hdr   = 1;
`else
        m_busy  = 1;
`endif
      end
    end else if (xfer) begin
      w       = q[m_owner].pop_front();
      m_write = 1'b1;
      m_data  = w[63:0];
      m_words++;
      if (w[64] || (m_words == MB)) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    if (m_write) m_writes++;
    @(posedge clock);
    #1;
    chk("tpc_write", tpc_write, m_write);
    if (m_write) chk("tpc_data", tpc_data, m_data);
    chk("busy", busy, m_busy);
    chk("grant_idx", grant_idx, 64'(m_owner));
    drive();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((total_left() > 0) && (n < budget)) begin
      cycle();
      n++;
    end
    chk("drain", 64'(total_left()), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tpc_ready = 1'b0;
    model_reset();
    m_writes  = 0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_tpc_write", tpc_write, 0);
    chk("rst_tpc_data", tpc_data, 0);
    chk("rst_req_read", req_read, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    drive();

    // Single requester, 5-word packet, ready held high
    p_valid = 100;
    p_ready = 100;
    push_packet(0, 5, 1);
    drive();
    run_until_empty(40);
    cycle();
    chk("single_busy_end", busy, 0);
    chk("single_grant_end", grant_idx, 0);

    // All four requesters valid with repeated 3-word packets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) push_packet(i, 3, 1);
    end
    drive();
    run_until_empty(200);

    // tpc_ready toggling mid-burst
    toggle_ready = 1;
    push_packet(2, 6, 1);
    push_packet(3, 4, 1);
    drive();
    run_until_empty(100);
    toggle_ready = 0;

    // Randomized traffic with occasional flushes
    p_valid = 70;
    p_ready = 70;
    p_flush = 2;
    for (int k = 0; k < 60; k++) begin
      push_packet($urandom_range(N - 1), $urandom_range(7, 1), 1);
    end
    drive();
    run_until_empty(3000);
    p_flush = 0;
    repeat (4) cycle();

    // Burst limit: requester 1 streams 10 words without last, requester 2 competes
    p_valid = 100;
    p_ready = 100;
    push_packet(1, 10, 0);
    push_packet(2, 8, 1);
    drive();
    run_until_empty(100);
    flush = 1'b1;
    cycle();

    // Flush after word 2 of a 6-word packet
    push_packet(0, 6, 1);
    drive();
    m_writes = 0;
    for (int n = 0; (n < 20) && (m_writes < 2); n++) cycle();
    chk("flush_setup_words", 64'(m_writes), 64'd2);
    flush = 1'b1;
    cycle();
    chk("flush_data", tpc_data, 0);
    run_until_empty(60);

    // Asynchronous reset between edges mid-burst
    push_packet(2, 6, 1);
    drive();
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tpc_write", tpc_write, 0);
    chk("arst_tpc_data", tpc_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant_idx", grant_idx, 0);
    chk("arst_req_read", req_read, 0);
    model_reset();
    @(posedge clock);
    #3 rst_n = 1'b1;
    run_until_empty(60);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tpc_arbiter.md
Name: tpc_arbiter

Overview:
- Shares one to-PC (tpc) hififo channel (64-bit data, write strobe, ready) between N_REQ on-chip requesters.
- Round-robin grant per burst; a burst ends on the requester's last flag or after MAX_BURST words, whichever comes first.
- Sits between producers (e.g. sequencer, counters, loopback) and one hififo_pcie tpc port, all on the hififo clock.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 64, maximum words per grant (power of 2, 2..256)

Ports:
- clock  in  1  hififo clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; tie to the hififo fifo_reset of the tpc channel
- req_valid  in  N_REQ  requester i has a word on req_data[i]
- req_data  in  64*N_REQ  word i occupies bits [64i+63:64i]
- req_last  in  N_REQ  current word of requester i ends its packet
- req_read  out  N_REQ  one-cycle pop strobe to requester i (word consumed)
- tpc_ready  in  1  hififo tpc fifo_ready (space available)
- tpc_write  out  1  hififo fifo_rw for the tpc channel
- tpc_data  out  64  hififo fifo_data
- grant_idx  out  3  index of the current or last granted requester
- busy  out  1  high while in BURST state

Behaviour:
- Reset (rst_n low, async): state IDLE, rr pointer 0, burst count 0.
  - Outputs: tpc_write 0, tpc_data 0, req_read 0, grant_idx 0, busy 0.
- flush (sync, highest priority after reset): same values as reset on the next edge. Any word on the output register that cycle is dropped.
- FSM states: IDLE, BURST (plus HDR when TPC_ARB_HEADER_EN is defined).
- IDLE:
  - Choose the first i with req_valid[i], searching from rr pointer upward modulo N_REQ.
  - Latch grant_idx = i, clear burst count, then go to BURST (or HDR).
  - No valid requester: stay in IDLE.
- BURST:
  - Transfer condition: xfer = req_valid[g] && tpc_ready.
  - On xfer, in the same cycle: req_read[g] = 1 (combinational). Next edge: tpc_write = 1, tpc_data = req_data[g], burst count +1.
  - Latency: one clock from req_valid&tpc_ready to tpc_write.
  - tpc_write is high only in the cycle after an xfer; at most one word per cycle.
  - Full throughput: one word/clock while valid and ready are both held high.
  - End of burst on xfer with req_last[g] = 1, or on xfer with count = MAX_BURST-1.
    - Set rr pointer = (g+1) mod N_REQ and return to IDLE.
    - Minimum one idle cycle between bursts; no same-cycle regrant.
  - req_valid[g] low mid-burst: grant is held (packet integrity); wait indefinitely.
  - tpc_ready low: no xfer, no req_read, state held.
- Simultaneous events:
  - flush beats xfer.
  - In IDLE, a requester asserting req_valid in the same cycle as another is resolved purely by rr order.
- Fairness: each of K continuously valid requesters is granted exactly once per K bursts.
- Counter width: clog2(MAX_BURST) bits; it never wraps because the burst ends at MAX_BURST.
- req_read is never asserted for a non-granted requester; it is zero in IDLE and HDR.

Optional Feature:
- Macro: TPC_ARB_HEADER_EN.
- Defined:
  - HDR state is entered from IDLE.
  - When tpc_ready is high, one header word is written with no req_read. Header word: [63:56] = 8'hA5, [55:48] = grant_idx, [47:32] = 16-bit per-arbiter burst sequence number (increments per header, wraps at 16'hFFFF to 0, reset and flush to 0), [31:0] = 0.
  - Then BURST.
  - MAX_BURST counts data words only.
- Not defined: no HDR state, no header logic, no sequence counter; IDLE goes directly to BURST.

Decomposition:
- Shared package hififo_pkg:
  - Constants TPC_HDR_MAGIC = 8'hA5 and HIFIFO_DW = 64.
  - Arbiter state enum (ARB_IDLE, ARB_HDR, ARB_BURST).
- One sub-module: rr_pick, combinational round-robin priority encoder (valid vector and pointer in; index and found out). It is reusable for an fpc-side dispatcher.

Test Plan:
- Single requester 0, 5-word packet (last on word 5), tpc_ready = 1: five tpc_write pulses on consecutive cycles, each one cycle after its req_read[0], data in order; busy then falls and grant_idx = 0.
- Requesters 0..3 all valid, 3-word packets, repeated: grant order 0,1,2,3,0,...; exactly one idle cycle between bursts; no interleaving of words within a packet.
- MAX_BURST = 4, requester 1 streams 10 words with no last while requester 2 is valid: 4 words from 1, then 4 from 2 (if 2 is continuous), then 1 resumes.
- tpc_ready toggling 1,0,1,0 mid-burst: req_read and tpc_write are only present after ready-high cycles; no word lost or duplicated (scoreboard check).
- flush asserted mid-burst after word 2 of 6: next cycle tpc_write = 0, busy = 0, grant pointer = 0; rst_n pulsed low asynchronously between edges clears outputs immediately.
- TPC_ARB_HEADER_EN defined, two bursts from requester 3: header words 64'hA503_0000_0000_0000 and 64'hA503_0001_0000_0000, each preceding its data.
